// File: rtl/fpu_pkg.sv
// Shared types and constants for the 9-bit minifloat add/sub unit.
// Format: [8] sign, [7:4] biased exponent, [3:0] mantissa with hidden 1.
package fpu_pkg;

  localparam int EXP_W  = 4;
  localparam int MAN_W  = 4;
  localparam int BIAS   = 7;
  localparam int FP_W   = 1 + EXP_W + MAN_W;
  // Hidden bit + mantissa + guard/round/sticky.
  localparam int EXT_W  = MAN_W + 4;
  localparam int SUM_W  = EXT_W + 1;
  localparam int EXPS_W = EXP_W + 3;
  localparam int SH_W   = $clog2(EXT_W);
  localparam int LZ_W   = $clog2(EXT_W + 1);

  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  localparam logic [FP_W-1:0] FP_ZERO = 9'h000;
  localparam logic [FP_W-1:0] FP_INF  = 9'h0F0;
  localparam logic [FP_W-1:0] FP_NAN  = 9'h0F8;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } fpu_state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mant;
  } fp_t;

  function automatic logic fp_is_nan(input fp_t x);
    return (x.exp == EXP_ONES) && (x.mant != '0);
  endfunction

  function automatic logic fp_is_inf(input fp_t x);
    return (x.exp == EXP_ONES) && (x.mant == '0);
  endfunction

  function automatic logic fp_is_zero(input fp_t x);
    return x.exp == '0;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter and left-normalising shifter for the aligned sum.
// An all-zero input reports zero_o with cnt_o = W.
module fp_lzc
  import fpu_pkg::*;
#(
  parameter int W = EXT_W,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  val_i,
  output logic [CW-1:0] cnt_o,
  output logic [W-1:0]  norm_o,
  output logic          zero_o
);

  // Scan upward so the highest set bit is the last writer.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (val_i[i]) begin
        cnt_o = CW'(W - 1 - i);
      end
    end
  end

  assign norm_o = val_i << cnt_o;
  assign zero_o = ~|val_i;

endmodule

// File: rtl/fp_addsub_unit.sv
// Multi-cycle minifloat add/subtract: IDLE->ALIGN->ADD->NORM->ROUND->DONE.
// Define FPU_RNE_EN for round-to-nearest-even; otherwise ROUND truncates.
module fp_addsub_unit
  import fpu_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic [FP_W-1:0] bus_i,
  input  logic            AFin,
  input  logic            GFin,
  input  logic            AddSubF,
  input  logic            GFout,
  output logic [FP_W-1:0] gf_bus_o,
  output logic [FP_W-1:0] gf_o,
  output logic            busy,
  output logic            fdone,
  output logic            ovf,
  output logic            unf
);

`ifdef FPU_RNE_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  localparam logic signed [EXPS_W-1:0] EXP_SAT  = EXPS_W'(int'(EXP_ONES));
  localparam logic signed [EXPS_W-1:0] EXP_ZERO = '0;

  fpu_state_t state_q, state_d;

  logic [FP_W-1:0]          af_q, gf_q, spec_res_q;
  fp_t                      a_q, b_q;
  logic                     op_q, sign_q, eff_sub_q, special_q, zero_q;
  logic                     ovf_q, unf_q;
  logic [EXT_W-1:0]         big_q, small_q, norm_q;
  logic [SUM_W-1:0]         sum_q;
  logic signed [EXPS_W-1:0] exp_q;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (GFin) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- ALIGN: swap, shift, specials ----------------
  fp_t                 b_eff, lg, sm;
  logic                a_ge_b;
  logic [EXP_W-1:0]    exp_diff;
  logic [SH_W-1:0]     shamt;
  logic [2*EXT_W-1:0]  sm_wide;
  logic [EXT_W-1:0]    small_aln;
  logic                spec_hit;
  logic [FP_W-1:0]     spec_val;

  always_comb begin
    b_eff  = {b_q.sign ^ op_q, b_q.exp, b_q.mant};
    a_ge_b = {a_q.exp, a_q.mant} >= {b_q.exp, b_q.mant};
    lg     = a_ge_b ? a_q : b_eff;
    sm     = a_ge_b ? b_eff : a_q;
    exp_diff = lg.exp - sm.exp;
    shamt  = (exp_diff > EXP_W'(EXT_W - 1)) ? SH_W'(EXT_W - 1) : exp_diff[SH_W-1:0];
    sm_wide   = {1'b1, sm.mant, 3'b000, {EXT_W{1'b0}}} >> shamt;
    // Everything shifted past the round bit collapses into sticky.
    small_aln = {sm_wide[2*EXT_W-1:EXT_W+1], sm_wide[EXT_W] | (|sm_wide[EXT_W-1:0])};
  end

  always_comb begin
    spec_hit = 1'b1;
    spec_val = FP_ZERO;
    if (fp_is_nan(a_q) || fp_is_nan(b_q)) begin
      spec_val = FP_NAN;
    end else if (fp_is_inf(a_q) && fp_is_inf(b_q)) begin
      spec_val = (a_q.sign == b_eff.sign) ? a_q : FP_NAN;
    end else if (fp_is_inf(a_q)) begin
      spec_val = a_q;
    end else if (fp_is_inf(b_q)) begin
      spec_val = b_eff;
    end else if (fp_is_zero(a_q)) begin
      spec_val = b_eff;
    end else if (fp_is_zero(b_q)) begin
      spec_val = a_q;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // ---------------- ADD ----------------
  logic [SUM_W-1:0] sum_d;

  always_comb begin
    if (eff_sub_q) begin
      sum_d = {1'b0, big_q} - {1'b0, small_q};
    end else begin
      sum_d = {1'b0, big_q} + {1'b0, small_q};
    end
  end

  // ---------------- NORM ----------------
  logic [LZ_W-1:0]          lz_cnt;
  logic [EXT_W-1:0]         lz_norm, norm_d;
  logic                     lz_zero;
  logic signed [EXPS_W-1:0] exp_norm_d;

  fp_lzc #(.W(EXT_W)) u_lzc (
    .val_i  (sum_q[EXT_W-1:0]),
    .cnt_o  (lz_cnt),
    .norm_o (lz_norm),
    .zero_o (lz_zero)
  );

  always_comb begin
    norm_d     = lz_norm;
    exp_norm_d = exp_q - EXPS_W'(lz_cnt);
    if (sum_q[SUM_W-1]) begin
      norm_d     = {sum_q[SUM_W-1:2], |sum_q[1:0]};
      exp_norm_d = exp_q + EXPS_W'(1);
    end
  end

  // ---------------- ROUND ----------------
  logic                     round_up;
  logic [MAN_W+1:0]         man_r;
  logic [MAN_W-1:0]         mant_r;
  logic signed [EXPS_W-1:0] exp_r;
  logic [FP_W-1:0]          res_d;
  logic                     ovf_d, unf_d;

  always_comb begin
    round_up = RNE_EN & norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    man_r    = {1'b0, norm_q[EXT_W-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    exp_r    = exp_q + EXPS_W'(man_r[MAN_W+1]);
    mant_r   = man_r[MAN_W+1] ? '0 : man_r[MAN_W-1:0];
    res_d    = {sign_q, exp_r[EXP_W-1:0], mant_r};
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (special_q) begin
      res_d = spec_res_q;
    end else if (zero_q) begin
      res_d = FP_ZERO;
    end else if (exp_r >= EXP_SAT) begin
      res_d = {sign_q, FP_INF[FP_W-2:0]};
      ovf_d = 1'b1;
    end else if (exp_r <= EXP_ZERO) begin
      res_d = FP_ZERO;
      unf_d = 1'b1;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      af_q       <= '0;
      gf_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      sign_q     <= 1'b0;
      eff_sub_q  <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= FP_ZERO;
      big_q      <= '0;
      small_q    <= '0;
      sum_q      <= '0;
      norm_q     <= '0;
      zero_q     <= 1'b0;
      exp_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      if (AFin) af_q <= bus_i;
      case (state_q)
        IDLE: begin
          if (GFin) begin
            a_q  <= af_q;
            b_q  <= bus_i;
            op_q <= AddSubF;
          end
        end
        ALIGN: begin
          sign_q     <= lg.sign;
          eff_sub_q  <= a_q.sign ^ b_eff.sign;
          big_q      <= {1'b1, lg.mant, 3'b000};
          small_q    <= small_aln;
          exp_q      <= EXPS_W'(lg.exp);
          special_q  <= spec_hit;
          spec_res_q <= spec_val;
        end
        ADD: sum_q <= sum_d;
        NORM: begin
          norm_q <= norm_d;
          exp_q  <= exp_norm_d;
          zero_q <= lz_zero & ~sum_q[SUM_W-1];
        end
        // GF lands on the edge into DONE so it is valid alongside fdone.
        ROUND: begin
          gf_q  <= res_d;
          ovf_q <= ovf_d;
          unf_q <= unf_d;
        end
        default: ;
      endcase
    end
  end

  assign gf_o     = gf_q;
  assign gf_bus_o = GFout ? gf_q : '0;
  assign busy     = (state_q != IDLE);
  assign fdone    = (state_q == DONE);
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

// File: tb/tb_fp_addsub_unit.sv
// Directed-vector bench for fp_addsub_unit; expected results are hand-computed.
module tb_fp_addsub_unit;

  logic       clk;
  logic       resetn;
  logic [8:0] bus_i;
  logic       AFin, GFin, AddSubF, GFout;
  logic [8:0] gf_bus_o, gf_o;
  logic       busy, fdone, ovf, unf;

  int n_tests = 0;
  int n_fail  = 0;
  int fdone_cnt = 0;

  fp_addsub_unit dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus_i    (bus_i),
    .AFin     (AFin),
    .GFin     (GFin),
    .AddSubF  (AddSubF),
    .GFout    (GFout),
    .gf_bus_o (gf_bus_o),
    .gf_o     (gf_o),
    .busy     (busy),
    .fdone    (fdone),
    .ovf      (ovf),
    .unf      (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fdone === 1'b1) fdone_cnt <= fdone_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_af(input logic [8:0] v);
    @(negedge clk);
    AFin  = 1'b1;
    bus_i = v;
  endtask

  // Starts A op B; optionally pokes AFin / a second GFin at loop cycle afin_at / gfin_at.
  task automatic do_op(input string tag, input logic [8:0] a, input logic [8:0] b,
                       input logic op, input logic [8:0] exp_gf, input logic chk_flags,
                       input logic exp_ovf, input logic exp_unf,
                       input int afin_at, input logic [8:0] afin_val, input int gfin_at);
    int lat, hits;
    logic [8:0] gf_s;
    logic ovf_s, unf_s;
    lat = 0; hits = 0; gf_s = '0; ovf_s = 1'b0; unf_s = 1'b0;
    load_af(a);
    @(negedge clk);
    AFin = 1'b0; bus_i = b; AddSubF = op; GFin = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      GFin = 1'b0; AFin = 1'b0; bus_i = '0; AddSubF = 1'b0;
      if (c == 1) check_eq({tag, "_busy"}, busy, 1);
      if (c == afin_at) begin AFin = 1'b1; bus_i = afin_val; end
      if (c == gfin_at) begin GFin = 1'b1; bus_i = 9'h078; AddSubF = 1'b1; end
      @(posedge clk);
      #1;
      if (fdone) begin
        hits++;
        if (lat == 0) begin
          lat = c + 1; gf_s = gf_o; ovf_s = ovf; unf_s = unf;
        end
      end
    end
    check_eq({tag, "_lat"}, lat, 5);
    check_eq({tag, "_nfdone"}, hits, 1);
    check_eq({tag, "_gf"}, gf_s, exp_gf);
    if (chk_flags) begin
      check_eq({tag, "_ovf"}, ovf_s, exp_ovf);
      check_eq({tag, "_unf"}, unf_s, exp_unf);
    end
    check_eq({tag, "_idle"}, busy, 0);
    $display("[TB] %s: A=%h B=%h op=%0d -> gf=%h ovf=%0d unf=%0d", tag, a, b, op, gf_s, ovf_s, unf_s);
  endtask

  initial begin
    int cnt0;
    resetn = 1'b0; bus_i = '0; AFin = 1'b0; GFin = 1'b0; AddSubF = 1'b0; GFout = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    check_eq("rst_gf", gf_o, 0);
    check_eq("rst_bus", gf_bus_o, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_fdone", fdone, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_unf", unf, 0);

    do_op("one_plus_one", 9'h070, 9'h070, 1'b0, 9'h080, 1'b1, 1'b0, 1'b0, 0, 9'h000, 0);
    do_op("1p5_plus",     9'h078, 9'h078, 1'b0, 9'h088, 1'b1, 1'b0, 1'b0, 0, 9'h000, 0);
    do_op("1p5_minus",    9'h078, 9'h078, 1'b1, 9'h000, 1'b1, 1'b0, 1'b0, 0, 9'h000, 0);
    do_op("overflow",     9'h0EF, 9'h0EF, 1'b0, 9'h0F0, 1'b1, 1'b1, 1'b0, 0, 9'h000, 0);
    do_op("inf_m_inf",    9'h0F0, 9'h0F0, 1'b1, 9'h0F8, 1'b0, 1'b0, 1'b0, 0, 9'h000, 0);
`ifdef FPU_RNE_EN
    do_op("round_tie",    9'h071, 9'h020, 1'b0, 9'h072, 1'b1, 1'b0, 1'b0, 0, 9'h000, 0);
`else
    do_op("round_trunc",  9'h071, 9'h020, 1'b0, 9'h071, 1'b1, 1'b0, 1'b0, 0, 9'h000, 0);
`endif
    do_op("underflow",    9'h018, 9'h010, 1'b1, 9'h000, 1'b1, 1'b0, 1'b1, 0, 9'h000, 0);
    do_op("mixed_sign",   9'h080, 9'h170, 1'b0, 9'h070, 1'b1, 1'b0, 1'b0, 0, 9'h000, 0);
    do_op("neg_result",   9'h070, 9'h080, 1'b1, 9'h170, 1'b1, 1'b0, 1'b0, 0, 9'h000, 0);
    do_op("nan_in",       9'h0F8, 9'h070, 1'b0, 9'h0F8, 1'b0, 1'b0, 1'b0, 0, 9'h000, 0);
    do_op("inf_p_fin",    9'h0F0, 9'h070, 1'b0, 9'h0F0, 1'b0, 1'b0, 1'b0, 0, 9'h000, 0);
    do_op("zero_a_sub",   9'h000, 9'h070, 1'b1, 9'h170, 1'b0, 1'b0, 1'b0, 0, 9'h000, 0);

    // Second GFin two cycles after start and AF rewritten mid-flight.
    do_op("overlap",      9'h070, 9'h070, 1'b0, 9'h080, 1'b1, 1'b0, 1'b0, 1, 9'h0EF, 2);
    @(negedge clk);
    GFout = 1'b1;
    #1;
    check_eq("gfout_on", gf_bus_o, 9'h080);
    @(negedge clk);
    GFout = 1'b0;
    #1;
    check_eq("gfout_off", gf_bus_o, 0);

    // Reset asserted while the operation sits in NORM.
    load_af(9'h070);
    @(negedge clk);
    AFin = 1'b0; bus_i = 9'h070; AddSubF = 1'b0; GFin = 1'b1;
    @(negedge clk);
    GFin = 1'b0; bus_i = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_gf", gf_o, 0);
    check_eq("mid_rst_fdone", fdone, 0);
    cnt0 = fdone_cnt;
    @(negedge clk);
    resetn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("mid_rst_nofdone", fdone_cnt, cnt0);
    $display("[TB] mid_rst: busy=%0d gf=%h", busy, gf_o);
    do_op("after_rst",    9'h078, 9'h078, 1'b0, 9'h088, 1'b1, 1'b0, 1'b0, 0, 9'h000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
